// File: rtl/audio_dac_out_if.sv
// rtl/audio_dac_out_if.sv - sample/mute/bitstream bundle between tone mixer and DAC output stage
// master: upstream mixer and board-level observer; slave: audio_dac_out.
interface audio_dac_out_if;
  logic [15:0] sample_in;
  logic        sample_valid_in;
  logic        mute_in;
  logic        dac_out;
  logic        muted_out;

  modport master (
    output sample_in,
    output sample_valid_in,
    output mute_in,
    input  dac_out,
    input  muted_out
  );

  modport slave (
    input  sample_in,
    input  sample_valid_in,
    input  mute_in,
    output dac_out,
    output muted_out
  );
endinterface

// File: rtl/audio_dac_out.sv
// rtl/audio_dac_out.sv - mute-ramped sample latch feeding a first-order sigma-delta 1-bit DAC
// Optional AUDIO_DAC_DITHER_EN adds LFSR dither to the modulator input.
module audio_dac_out (
  input  logic            clk_in,
  input  logic            reset_n_in,
  audio_dac_out_if.slave  bus
);

  typedef enum logic [1:0] {
    MUTED     = 2'd0,
    RAMP_UP   = 2'd1,
    RUN       = 2'd2,
    RAMP_DOWN = 2'd3
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [4:0]         gain;
  logic [4:0]         gain_next;
  logic [15:0]        held;
  logic [15:0]        held_next;
  logic signed [21:0] prod;
  logic [15:0]        acc;
  logic [15:0]        u;
  logic [15:0]        mod_in;
  logic [16:0]        s;
  logic               dac_q;
  logic               muted_q;

  // Gain only moves on a strobe, one step per strobe, clamped to 0..16.
  always_comb begin
    state_next = state;
    gain_next  = gain;
    if (bus.sample_valid_in) begin
      case (state)
        MUTED: begin
          if (!bus.mute_in) begin
            gain_next  = 5'd1;
            state_next = RAMP_UP;
          end
        end
        RAMP_UP: begin
          if (bus.mute_in) begin
            gain_next  = gain - 5'd1;
            state_next = (gain == 5'd1) ? MUTED : RAMP_DOWN;
          end else begin
            gain_next  = gain + 5'd1;
            state_next = (gain == 5'd15) ? RUN : RAMP_UP;
          end
        end
        RUN: begin
          if (bus.mute_in) begin
            gain_next  = 5'd15;
            state_next = RAMP_DOWN;
          end
        end
        RAMP_DOWN: begin
          if (!bus.mute_in) begin
            gain_next  = gain + 5'd1;
            state_next = (gain == 5'd15) ? RUN : RAMP_UP;
          end else begin
            gain_next  = gain - 5'd1;
            state_next = (gain == 5'd1) ? MUTED : RAMP_DOWN;
          end
        end
        default: begin
          gain_next  = 5'd0;
          state_next = MUTED;
        end
      endcase
    end
  end

  always_comb begin
    prod      = $signed(bus.sample_in) * $signed({1'b0, gain_next});
    held_next = 16'(prod >>> 4);
  end

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state   <= MUTED;
      gain    <= 5'd0;
      held    <= 16'd0;
      muted_q <= 1'b1;
    end else begin
      state   <= state_next;
      gain    <= gain_next;
      muted_q <= (state_next == MUTED);
      if (bus.sample_valid_in) begin
        held <= held_next;
      end
    end
  end

  // Offset binary: signed zero maps to midscale, so silence is a 50% bitstream.
  assign u = held ^ 16'h8000;

`ifdef AUDIO_DAC_DITHER_EN
  logic [15:0] lfsr;
  logic [16:0] dith_sum;

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      lfsr <= 16'hACE1;
    end else begin
      lfsr <= {1'b0, lfsr[15:1]} ^ ({16{lfsr[0]}} & 16'hB400);
    end
  end

  assign dith_sum = {1'b0, u} + {13'd0, lfsr[3:0]};
  assign mod_in   = dith_sum[16] ? 16'hFFFF : dith_sum[15:0];
`else
  assign mod_in = u;
`endif

  assign s = {1'b0, acc} + {1'b0, mod_in};

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      acc   <= 16'd0;
      dac_q <= 1'b0;
    end else begin
      acc   <= s[15:0];
      dac_q <= s[16];
    end
  end

  assign bus.dac_out   = dac_q;
  assign bus.muted_out = muted_q;

endmodule

// File: tb/tb_audio_dac_out.sv
// tb/tb_audio_dac_out.sv - scoreboard bench for audio_dac_out (dither macro undefined)
module tb_audio_dac_out;

  logic clk_in;
  logic reset_n_in;

  audio_dac_out_if bus ();

  audio_dac_out dut (
    .clk_in     (clk_in),
    .reset_n_in (reset_n_in),
    .bus        (bus)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  typedef struct {
    logic        dac;
    logic        muted;
    logic [4:0]  gain;
    logic [15:0] held;
  } exp_t;

  exp_t q[$];

  int checks   = 0;
  int failures = 0;

  int          m_gain;
  logic [15:0] m_held;
  logic [15:0] m_acc;
  int          ones;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_gain = 0;
    m_held = 16'd0;
    m_acc  = 16'd0;
    q.delete();
  endtask

  // Gain behaves as a saturating up/down counter; state is implied by it.
  task automatic cyc(input logic v, input logic [15:0] smp, input logic m);
    exp_t        e;
    exp_t        got;
    logic [16:0] sum;
    int          p;
    int          ps;
    bus.sample_valid_in = v;
    bus.sample_in       = smp;
    bus.mute_in         = m;
    sum   = {1'b0, m_acc} + {1'b0, (m_held ^ 16'h8000)};
    e.dac = sum[16];
    m_acc = sum[15:0];
    if (v) begin
      if (m) begin
        if (m_gain > 0) m_gain--;
      end else begin
        if (m_gain < 16) m_gain++;
      end
      p      = $signed(smp) * m_gain;
      ps     = p >>> 4;
      m_held = ps[15:0];
    end
    e.muted = (m_gain == 0);
    e.gain  = 5'(m_gain);
    e.held  = m_held;
    q.push_back(e);
    @(posedge clk_in);
    #1;
    bus.sample_valid_in = 1'b0;
    got = q.pop_front();
    chk("dac_out",   {31'd0, bus.dac_out},   {31'd0, got.dac});
    chk("muted_out", {31'd0, bus.muted_out}, {31'd0, got.muted});
    chk("gain",      {27'd0, dut.gain},      {27'd0, got.gain});
    chk("held",      {16'd0, dut.held},      {16'd0, got.held});
  endtask

  task automatic idle(input int n, input logic m);
    ones = 0;
    for (int i = 0; i < n; i++) begin
      cyc(1'b0, 16'h0000, m);
      ones += int'(bus.dac_out);
    end
  endtask

  initial begin
    reset_n_in          = 1'b0;
    bus.sample_in       = 16'd0;
    bus.sample_valid_in = 1'b0;
    bus.mute_in         = 1'b0;
    model_reset();
    repeat (3) @(posedge clk_in);
    #1;
    chk("reset_dac",   {31'd0, bus.dac_out},   32'd0);
    chk("reset_muted", {31'd0, bus.muted_out}, 32'd1);
    chk("reset_gain",  {27'd0, dut.gain},      32'd0);
    chk("reset_held",  {16'd0, dut.held},      32'd0);
    #1;
    reset_n_in = 1'b1;

    // Full ramp-up, back-to-back strobes
    for (int i = 0; i < 16; i++) cyc(1'b1, 16'h4000, 1'b0);
    chk("ramp_gain16", {27'd0, dut.gain}, 32'd16);
    chk("ramp_held",   {16'd0, dut.held}, 32'h4000);
    chk("ramp_muted",  {31'd0, bus.muted_out}, 32'd0);
    idle(4, 1'b0);
    chk("density_3of4", ones, 32'd3);
    idle(4, 1'b0);

    cyc(1'b1, 16'h0000, 1'b0);
    idle(6, 1'b0);

    cyc(1'b1, 16'h8000, 1'b0);
    idle(20, 1'b0);
    chk("neg_fullscale_zero", ones, 32'd0);

    cyc(1'b1, 16'h7FFF, 1'b0);
    idle(20, 1'b0);
    chk("pos_fullscale_ones", ones >= 19, 32'd1);

    // Ramp down with spaced strobes
    cyc(1'b1, 16'h2000, 1'b1);
    chk("down_gain15", {27'd0, dut.gain}, 32'd15);
    chk("down_held",   {16'd0, dut.held}, 32'h1E00);
    for (int i = 0; i < 15; i++) begin
      cyc(1'b1, 16'h2000, 1'b1);
      idle(2, 1'b1);
    end
    chk("muted_flag", {31'd0, bus.muted_out}, 32'd1);
    chk("muted_held", {16'd0, dut.held},      32'd0);
    cyc(1'b1, 16'h2000, 1'b1);
    chk("stay_muted", {27'd0, dut.gain}, 32'd0);
    idle(4, 1'b1);
    chk("silence_half", ones, 32'd2);

    // Up again, then down to gain 8, then reverse
    for (int i = 0; i < 16; i++) cyc(1'b1, 16'h1234, 1'b0);
    for (int i = 0; i < 8; i++) cyc(1'b1, 16'hC000, 1'b1);
    chk("mid_gain8", {27'd0, dut.gain}, 32'd8);
    cyc(1'b1, 16'hC000, 1'b0);
    chk("reverse_gain9", {27'd0, dut.gain}, 32'd9);
    chk("reverse_state", {30'd0, dut.state}, 32'd1);

    // Asynchronous reset mid-ramp, checked before the next edge
    #2;
    reset_n_in = 1'b0;
    #1;
    chk("async_dac",   {31'd0, bus.dac_out},   32'd0);
    chk("async_muted", {31'd0, bus.muted_out}, 32'd1);
    chk("async_gain",  {27'd0, dut.gain},      32'd0);
    model_reset();
    @(posedge clk_in);
    #2;
    reset_n_in = 1'b1;
    cyc(1'b1, 16'h4000, 1'b0);
    chk("restart_gain1", {27'd0, dut.gain}, 32'd1);
    idle(3, 1'b0);

    chk("scoreboard_empty", q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL timeout observed=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
